// File: rtl/first_nios2_system_buttons_pio_pkg.sv
// Shared constants for the buttons PIO.
//   Register word offsets: DATA, IRQMASK and EDGECAP. Offset 1 is unused.
//   Edge-capture selectors used by the EDGE_TYPE parameter.
//   Width helper used to size the debounce counter.
package first_nios2_system_buttons_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Number of bits needed for a counter that runs from 0 to cycles-1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/first_nios2_system_pio_debounce.sv
// One-bit input conditioner: 2-flop synchroniser followed by a debounce filter.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   raw asynchronous input bit
//   dout     out  debounced bit (synchronised only when DEBOUNCE_CYCLES = 0)
module first_nios2_system_pio_debounce
  import first_nios2_system_buttons_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic sync_meta;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= din;
      sync_q    <= sync_meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign dout = sync_q;
    end else begin : g_filter
      localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          stable_q;

      // The counter only runs while the synchronised input disagrees with the
      // accepted value; any agreement restarts the qualification window. The
      // DEBOUNCE_CYCLES-th consecutive disagreeing clock accepts the new value.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt      <= '0;
          stable_q <= 1'b0;
        end else if (sync_q == stable_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable_q <= sync_q;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign dout = stable_q;
    end
  endgenerate

endmodule

// File: rtl/first_nios2_system_buttons_pio.sv
// Avalon-MM input PIO for push-buttons/switches with edge capture and IRQ.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   word offset: 0 DATA, 1 unused, 2 IRQMASK, 3 EDGECAP (W1C)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   readdata    out  registered read data, latency 1
//   in_port     in   asynchronous external inputs
//   irq         out  active-high level interrupt
module first_nios2_system_buttons_pio
  import first_nios2_system_buttons_pio_pkg::*;
#(
  parameter int          WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_TYPE       = EDGE_FALLING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    first_nios2_system_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .dout    (stable[i])
    );
  end

  // prev resets to 0, so an input that is high out of reset looks like a
  // rising edge once it has been accepted.
  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_edge_rise
      assign edge_hit = stable & ~prev;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_fall
      assign edge_hit = ~stable & prev;
    end else begin : g_edge_any
      assign edge_hit = stable ^ prev;
    end
  endgenerate

  assign wr_en   = chipselect & ~write_n;
  assign cap_clr = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Upper write-data bits have no storage behind them.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
    end else begin
      prev <= stable;
      // Clear first, then OR in new edges so a capture is never lost to a
      // simultaneous write-one-to-clear.
      edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
      if (wr_en && address == PIO_ADDR_IRQMASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        PIO_ADDR_DATA:    readdata <= 32'(stable);
        PIO_ADDR_IRQMASK: readdata <= 32'(irq_mask);
        PIO_ADDR_EDGECAP: readdata <= 32'(edge_cap);
        default:          readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_first_nios2_system_buttons_pio.sv
module tb_first_nios2_system_buttons_pio;

  localparam int DC_A = 4;

  logic        clk;
  logic        rst_a, rst_b;
  logic [1:0]  addr_a, addr_b;
  logic        cs_a, cs_b, wn_a, wn_b;
  logic [31:0] wd_a, wd_b, rd_a, rd_b;
  logic [3:0]  in_a, in_b;
  logic        irq_a, irq_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  first_nios2_system_buttons_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DC_A), .EDGE_TYPE(1)) dut_a (
    .clk(clk), .reset_n(rst_a), .address(addr_a), .chipselect(cs_a), .write_n(wn_a),
    .writedata(wd_a), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  first_nios2_system_buttons_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(rst_b), .address(addr_b), .chipselect(cs_b), .write_n(wn_b),
    .writedata(wd_b), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model for dut_a ----------------
  // A new input level is accepted once the synchronised input (the sample taken
  // two clocks earlier) has disagreed with the accepted level for DC_A samples
  // in a row. Captures record falling edges of the accepted level.
  logic [7:0][3:0] hist;   // hist[0] = newest in_port sample
  logic [3:0]  m_stable, m_prev, m_cap, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  function automatic logic [3:0] next_stable(input logic [7:0][3:0] h, input logic [3:0] cur);
    logic [3:0] r;
    logic       all_diff;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DC_A + 1; j++)
        if (h[j][b] == cur[b]) all_diff = 1'b0;
      if (all_diff) r[b] = ~cur[b];
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_mux(input logic [1:0] a, input logic [3:0] d,
                                         input logic [3:0] m, input logic [3:0] c);
    case (a)
      2'd0:    return {28'b0, d};
      2'd2:    return {28'b0, m};
      2'd3:    return {28'b0, c};
      default: return 32'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      hist     <= '0;
      m_stable <= 4'h0;
      m_prev   <= 4'h0;
      m_cap    <= 4'h0;
      m_mask   <= 4'h0;
      m_rd     <= 32'h0;
    end else begin
      m_rd <= rd_mux(addr_a, m_stable, m_mask, m_cap);
      if (cs_a && !wn_a && addr_a == 2'd2) m_mask <= wd_a[3:0];
      m_cap <= (m_cap & ~((cs_a && !wn_a && addr_a == 2'd3) ? wd_a[3:0] : 4'h0))
               | (m_prev & ~m_stable);
      hist     <= {hist[6:0], in_a};
      m_prev   <= m_stable;
      m_stable <= next_stable({hist[6:0], in_a}, m_stable);
    end
  end

  assign m_irq = |(m_cap & m_mask);

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_irq_a", {31'b0, irq_a}, {31'b0, m_irq});
      check("model_readdata_a", rd_a, m_rd);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_wr(input bit b, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    if (!b) begin addr_a = a; wd_a = d; cs_a = 1'b1; wn_a = 1'b0; end
    else    begin addr_b = a; wd_b = d; cs_b = 1'b1; wn_b = 1'b0; end
    @(negedge clk);
    if (!b) begin cs_a = 1'b0; wn_a = 1'b1; end
    else    begin cs_b = 1'b0; wn_b = 1'b1; end
  endtask

  task automatic bus_rd(input bit b, input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    if (!b) begin addr_a = a; cs_a = 1'b1; end
    else    begin addr_b = a; cs_b = 1'b1; end
    @(negedge clk);
    d = b ? rd_b : rd_a;
    if (!b) cs_a = 1'b0; else cs_b = 1'b0;
  endtask

  task automatic rd_check(input bit b, input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(b, a, v);
    check(nm, v, exp);
  endtask

  typedef struct {
    logic [3:0]  in_val;
    int          hold;
    bit          do_rd;
    logic [1:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;

    vecs[0] = '{4'hF, 10, 1'b1, 2'd0, 32'hF};  // reset release with inputs high
    vecs[1] = '{4'hF,  0, 1'b1, 2'd3, 32'h0};  // no falling edge yet
    vecs[2] = '{4'hE,  3, 1'b0, 2'd0, 32'h0};  // 3-clock glitch on bit0
    vecs[3] = '{4'hF, 10, 1'b1, 2'd0, 32'hF};  // glitch rejected
    vecs[4] = '{4'hF,  0, 1'b1, 2'd3, 32'h0};  // and not captured
    vecs[5] = '{4'hE, 10, 1'b1, 2'd0, 32'hE};  // long low accepted
    vecs[6] = '{4'hE,  0, 1'b1, 2'd3, 32'h1};  // falling edge captured

    rst_a = 1'b0; rst_b = 1'b0;
    cs_a = 1'b0; wn_a = 1'b1; addr_a = 2'd0; wd_a = '0; in_a = 4'hF;
    cs_b = 1'b0; wn_b = 1'b1; addr_b = 2'd0; wd_b = '0; in_b = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_irq_a", {31'b0, irq_a}, 32'h0);
    check("reset_readdata_a", rd_a, 32'h0);
    rst_a = 1'b1; rst_b = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      in_a = vecs[i].in_val;
      repeat (vecs[i].hold) @(negedge clk);
      if (vecs[i].do_rd) rd_check(1'b0, $sformatf("vec%0d", i), vecs[i].rd_addr, vecs[i].exp);
    end
    check("irq_after_reset", {31'b0, irq_a}, 32'h0);

    // IRQ enable and W1C
    bus_wr(1'b0, 2'd2, 32'h1);
    check("irq_mask_on", {31'b0, irq_a}, 32'h1);
    bus_wr(1'b0, 2'd3, 32'h1);
    check("irq_w1c", {31'b0, irq_a}, 32'h0);
    rd_check(1'b0, "edgecap_cleared", 2'd3, 32'h0);

    // Masking
    in_a = 4'hA;
    repeat (10) @(negedge clk);
    rd_check(1'b0, "edgecap_bit2", 2'd3, 32'h4);
    check("irq_masked", {31'b0, irq_a}, 32'h0);
    bus_wr(1'b0, 2'd2, 32'h5);
    check("irq_unmasked", {31'b0, irq_a}, 32'h1);
    bus_wr(1'b0, 2'd2, 32'h0);
    check("irq_remasked", {31'b0, irq_a}, 32'h0);
    rd_check(1'b0, "edgecap_kept", 2'd3, 32'h4);

    // W1C of bit1 lands on the same clock as bit1's falling-edge capture
    in_a = 4'h8;
    repeat (2 + DC_A) @(negedge clk);
    addr_a = 2'd3; wd_a = 32'h2; cs_a = 1'b1; wn_a = 1'b0;
    @(negedge clk);
    cs_a = 1'b0; wn_a = 1'b1;
    rd_check(1'b0, "collision_set_wins", 2'd3, 32'h6);
    rd_check(1'b0, "addr1_reads_zero", 2'd1, 32'h0);
    bus_wr(1'b0, 2'd0, 32'hFF);
    rd_check(1'b0, "data_write_ignored", 2'd0, 32'h8);
    rd_check(1'b0, "mask_untouched", 2'd2, 32'h0);
    rd_check(1'b0, "cap_untouched", 2'd3, 32'h6);

    // Randomised traffic against the model
    hold = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        in_a = 4'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      cs_a   = 1'($urandom);
      wn_a   = ($urandom_range(0, 3) != 0);
      addr_a = 2'($urandom);
      wd_a   = $urandom;
    end
    @(negedge clk);
    cs_a = 1'b0; wn_a = 1'b1;

    // dut_b: no debounce, any edge
    rd_check(1'b1, "b_first_high_fires", 2'd3, 32'hF);
    rd_check(1'b1, "b_data", 2'd0, 32'hF);
    bus_wr(1'b1, 2'd3, 32'hF);
    rd_check(1'b1, "b_cap_clear", 2'd3, 32'h0);
    in_b = 4'h7;
    repeat (4) @(negedge clk);
    rd_check(1'b1, "b_data_low", 2'd0, 32'h7);
    rd_check(1'b1, "b_fall_cap", 2'd3, 32'h8);
    bus_wr(1'b1, 2'd3, 32'h8);
    rd_check(1'b1, "b_cap_clear2", 2'd3, 32'h0);
    in_b = 4'hF;
    repeat (4) @(negedge clk);
    rd_check(1'b1, "b_rise_cap", 2'd3, 32'h8);
    bus_wr(1'b1, 2'd2, 32'h8);
    check("b_irq", {31'b0, irq_b}, 32'h1);
    addr_b = 2'd3;
    in_b = 4'h7;
    @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("b_async_irq", {31'b0, irq_b}, 32'h0);
    check("b_async_readdata", rd_b, 32'h0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    rd_check(1'b1, "b_mask_after_reset", 2'd2, 32'h0);
    rd_check(1'b1, "b_cap_after_reset", 2'd3, 32'h7);
    rd_check(1'b1, "b_data_after_reset", 2'd0, 32'h7);
    check("b_irq_after_reset", {31'b0, irq_b}, 32'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
